// File: rtl/ip4_rtl_spa_issue_if.sv
// rtl/ip4_rtl_spa_issue_if.sv - decoder, spa issue and writeback signal bundle for the issue queue
//
// Purpose : groups the three handshakes around the issue queue.
//   decoder -> queue : in_vld/in_rdy with in_op, in_dst(_en), in_sa(_en), in_sb(_en)
//   queue   -> spa   : iss_vld/iss_rdy with iss_op, iss_dst(_en), iss_sa, iss_sb
//   spa     -> queue : wb_vld with wb_dst (no back-pressure)
// Modports:
//   master : the environment (decoder + spa) side
//   slave  : the issue queue side
interface ip4_rtl_spa_issue_if #(
    parameter int OP_W   = 24,
    parameter int REG_AW = 5
);
    logic              in_vld;
    logic              in_rdy;
    logic [OP_W-1:0]   in_op;
    logic [REG_AW-1:0] in_dst;
    logic              in_dst_en;
    logic [REG_AW-1:0] in_sa;
    logic              in_sa_en;
    logic [REG_AW-1:0] in_sb;
    logic              in_sb_en;

    logic              iss_vld;
    logic              iss_rdy;
    logic [OP_W-1:0]   iss_op;
    logic [REG_AW-1:0] iss_dst;
    logic              iss_dst_en;
    logic [REG_AW-1:0] iss_sa;
    logic [REG_AW-1:0] iss_sb;

    logic              wb_vld;
    logic [REG_AW-1:0] wb_dst;

    modport master (
        output in_vld, in_op, in_dst, in_dst_en, in_sa, in_sa_en, in_sb, in_sb_en,
        input  in_rdy,
        input  iss_vld, iss_op, iss_dst, iss_dst_en, iss_sa, iss_sb,
        output iss_rdy,
        output wb_vld, wb_dst
    );

    modport slave (
        input  in_vld, in_op, in_dst, in_dst_en, in_sa, in_sa_en, in_sb, in_sb_en,
        output in_rdy,
        output iss_vld, iss_op, iss_dst, iss_dst_en, iss_sa, iss_sb,
        input  iss_rdy,
        input  wb_vld, wb_dst
    );
endinterface

// File: rtl/ip4_rtl_spa_issue.sv
// rtl/ip4_rtl_spa_issue.sv - in-order issue queue with register scoreboard feeding the spa
//
// Purpose : buffers decoded instructions and releases the head only when none of
//           its used registers (sources or destination) is still pending a
//           writeback from an instruction already in flight in the spa.
// Ports   :
//   clk    in   clock
//   rst_n  in   synchronous reset, active-low
//   flush  in   drop all queued instructions and clear the scoreboard
//   bus    slave modport of ip4_rtl_spa_issue_if (enqueue, issue, writeback)
//   occ    out  number of entries currently held (0..DEPTH)
module ip4_rtl_spa_issue #(
    parameter int DEPTH  = 8,
    parameter int OP_W   = 24,
    parameter int REG_AW = 5,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    ip4_rtl_spa_issue_if.slave   bus,
    output logic [OCC_W-1:0]     occ
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int NREG  = 2 ** REG_AW;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [REG_AW-1:0] dst;
        logic              dst_en;
        logic [REG_AW-1:0] sa;
        logic              sa_en;
        logic [REG_AW-1:0] sb;
        logic              sb_en;
    } entry_t;

    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [NREG-1:0]   sb_q, sb_d;

    entry_t            head;
    entry_t            in_ent;
    logic [NREG-1:0]   pend;
    logic              full;
    logic              empty;
    logic              hz;
    logic              in_rdy;
    logic              iss_vld;
    logic              enq;
    logic              iss;

    assign head  = mem_q[rd_ptr_q];
    assign full  = (occ_q == OCC_W'(DEPTH));
    assign empty = (occ_q == '0);

    // r0 is hard-wired as never pending, independent of what sb_q holds.
    assign pend = {sb_q[NREG-1:1], 1'b0};

    // Hazard uses only registered state, so iss_vld never depends on iss_rdy.
    // A stalled head cannot gain new hazards because nothing issues past it.
    assign hz = (head.sa_en  & pend[head.sa])
              | (head.sb_en  & pend[head.sb])
              | (head.dst_en & pend[head.dst]);

    // Full blocks enqueue even if the head leaves this cycle (no pass-through).
    assign in_rdy  = rst_n & ~full & ~flush;
    assign iss_vld = rst_n & ~empty & ~hz & ~flush;

    assign enq = bus.in_vld & in_rdy;
    assign iss = iss_vld & bus.iss_rdy;

    assign in_ent = '{op:     bus.in_op,
                      dst:    bus.in_dst,
                      dst_en: bus.in_dst_en,
                      sa:     bus.in_sa,
                      sa_en:  bus.in_sa_en,
                      sb:     bus.in_sb,
                      sb_en:  bus.in_sb_en};

    always_comb begin
        sb_d     = sb_q;
        occ_d    = occ_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        // Writeback clear and issue set can never hit the same register:
        // an issuing head's destination is by construction not pending.
        if (bus.wb_vld) begin
            sb_d[bus.wb_dst] = 1'b0;
        end
        if (iss && head.dst_en && (head.dst != '0)) begin
            sb_d[head.dst] = 1'b1;
        end
        sb_d[0] = 1'b0;

        if (enq) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (iss) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case ({enq, iss})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Reset and flush are equivalent for state; flush also discards any
    // writeback in its cycle since the whole scoreboard is cleared.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            sb_q     <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            sb_q     <= sb_d;
        end
    end

    // Payload storage needs no reset: it is only read through occ/rd_ptr.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_q[wr_ptr_q] <= in_ent;
        end
    end

    assign bus.in_rdy     = in_rdy;
    assign bus.iss_vld    = iss_vld;
    assign bus.iss_op     = head.op;
    assign bus.iss_dst    = head.dst;
    assign bus.iss_dst_en = head.dst_en;
    assign bus.iss_sa     = head.sa;
    assign bus.iss_sb     = head.sb;
    assign occ            = occ_q;
endmodule
